// File: rtl/cam_pkg.sv
// Shared CAM definitions: default geometry, stats counter width and the
// lookup controller state encoding.
package cam_pkg;

  localparam int CAM_WIDTH       = 32;
  localparam int CAM_ADDR_WIDTH  = 5;
  localparam int CAM_STATS_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CHECK,
    WRITE,
    RESP
  } cam_ctrl_state_e;

endpackage

// File: rtl/cam_alloc_ptr.sv
// Wrapping allocation pointer (FIFO replacement once full) and
// saturating occupancy counter for the CAM lookup controller.
module cam_alloc_ptr
  import cam_pkg::*;
#(
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic [ADDR_WIDTH:0]   occupancy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;

  always_comb begin
    ptr_d = ptr_q;
    occ_d = occ_q;
    if (advance_i) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (occ_q != FULL) begin
        occ_d = occ_q + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      occ_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      occ_q <= occ_d;
    end
  end

  assign ptr_o       = ptr_q;
  assign occupancy_o = occ_q;

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Lookup-or-insert sequencer driving the search and write ports of the CAM.
// Optional hit/miss counters are enabled by CAM_LOOKUP_CTRL_STATS_EN.
//
// state  | meaning
// IDLE   | ready for a request
// SEARCH | search strobe to the CAM with the registered key
// CHECK  | CAM result sampled, hit / miss decided
// WRITE  | miss with insert: write key at the allocation pointer
// RESP   | response held until the consumer accepts it
module cam_lookup_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [WIDTH-1:0]           req_key_i,
  input  logic                       req_insert_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_hit_o,
  output logic                       rsp_inserted_o,
  output logic [ADDR_WIDTH-1:0]      rsp_index_o,
  output logic [ADDR_WIDTH:0]        occupancy_o,
`ifdef CAM_LOOKUP_CTRL_STATS_EN
  output logic [CAM_STATS_WIDTH-1:0] hit_count_o,
  output logic [CAM_STATS_WIDTH-1:0] miss_count_o,
`endif
  output logic                       cam_search_enable_o,
  output logic [WIDTH-1:0]           cam_search_data_o,
  input  logic                       cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0]      cam_search_index_i,
  output logic                       cam_write_enable_o,
  output logic [ADDR_WIDTH-1:0]      cam_write_index_o,
  output logic [WIDTH-1:0]           cam_write_data_o
);

  cam_ctrl_state_e state_q, state_d;

  logic [WIDTH-1:0]      key_q, key_d;
  logic                  insert_q, insert_d;
  logic                  hit_q, hit_d;
  logic                  inserted_q, inserted_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  alloc_advance;
  logic [ADDR_WIDTH-1:0] alloc_ptr;

  cam_alloc_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_alloc_ptr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .advance_i   (alloc_advance),
    .ptr_o       (alloc_ptr),
    .occupancy_o (occupancy_o)
  );

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    insert_d      = insert_q;
    hit_d         = hit_q;
    inserted_d    = inserted_q;
    index_d       = index_q;
    alloc_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          key_d    = req_key_i;
          insert_d = req_insert_i;
          state_d  = SEARCH;
        end
      end
      SEARCH: state_d = CHECK;
      CHECK: begin
        if (cam_search_valid_i) begin
          hit_d      = 1'b1;
          inserted_d = 1'b0;
          index_d    = cam_search_index_i;
          state_d    = RESP;
        end else if (insert_q) begin
          state_d = WRITE;
        end else begin
          hit_d      = 1'b0;
          inserted_d = 1'b0;
          index_d    = '0;
          state_d    = RESP;
        end
      end
      WRITE: begin
        alloc_advance = 1'b1;
        hit_d         = 1'b0;
        inserted_d    = 1'b1;
        index_d       = alloc_ptr;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      key_q      <= '0;
      insert_q   <= 1'b0;
      hit_q      <= 1'b0;
      inserted_q <= 1'b0;
      index_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      insert_q   <= insert_d;
      hit_q      <= hit_d;
      inserted_q <= inserted_d;
      index_q    <= index_d;
    end
  end

`ifdef CAM_LOOKUP_CTRL_STATS_EN
  logic [CAM_STATS_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == CHECK) begin
      if (cam_search_valid_i) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CAM_STATS_WIDTH'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CAM_STATS_WIDTH'(1);
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

  // CAM strobes decode straight from state so reset silences them at once
  assign req_ready_o         = (state_q == IDLE);
  assign rsp_valid_o         = (state_q == RESP);
  assign rsp_hit_o           = hit_q;
  assign rsp_inserted_o      = inserted_q;
  assign rsp_index_o         = index_q;
  assign cam_search_enable_o = (state_q == SEARCH);
  assign cam_search_data_o   = cam_search_enable_o ? key_q : '0;
  assign cam_write_enable_o  = (state_q == WRITE);
  assign cam_write_index_o   = cam_write_enable_o ? alloc_ptr : '0;
  assign cam_write_data_o    = cam_write_enable_o ? key_q : '0;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Directed bench for cam_lookup_ctrl with a small behavioural CAM attached.
module tb_cam_lookup_ctrl;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_key = '0;
  logic          req_insert = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_hit, rsp_inserted;
  logic [AW-1:0] rsp_index;
  logic [AW:0]   occupancy;
  logic          s_en, s_valid, w_en;
  logic [W-1:0]  s_data, w_data;
  logic [AW-1:0] s_index, w_index;
`ifdef CAM_LOOKUP_CTRL_STATS_EN
  logic [15:0]   hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int write_cnt = 0;
  logic [AW-1:0] last_widx;
  logic [W-1:0]  last_wdata;

  always #5 clk = ~clk;

  cam_lookup_ctrl dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_key_i           (req_key),
    .req_insert_i        (req_insert),
    .rsp_valid_o         (rsp_valid),
    .rsp_ready_i         (rsp_ready),
    .rsp_hit_o           (rsp_hit),
    .rsp_inserted_o      (rsp_inserted),
    .rsp_index_o         (rsp_index),
    .occupancy_o         (occupancy),
`ifdef CAM_LOOKUP_CTRL_STATS_EN
    .hit_count_o         (hit_count),
    .miss_count_o        (miss_count),
`endif
    .cam_search_enable_o (s_en),
    .cam_search_data_o   (s_data),
    .cam_search_valid_i  (s_valid),
    .cam_search_index_i  (s_index),
    .cam_write_enable_o  (w_en),
    .cam_write_index_o   (w_index),
    .cam_write_data_o    (w_data)
  );

  // Behavioural CAM: result one cycle after the search strobe, lowest index wins
  logic [W-1:0] cam_mem [2**AW];
  logic         cam_vld [2**AW];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        cam_mem[i] <= '0;
        cam_vld[i] <= 1'b0;
      end
      s_valid <= 1'b0;
      s_index <= '0;
    end else begin
      if (w_en) begin
        cam_mem[w_index] <= w_data;
        cam_vld[w_index] <= 1'b1;
      end
      s_valid <= 1'b0;
      s_index <= '0;
      if (s_en) begin
        for (int i = 2**AW - 1; i >= 0; i--) begin
          if (cam_vld[i] && cam_mem[i] == s_data) begin
            s_valid <= 1'b1;
            s_index <= AW'(i);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (w_en) begin
      write_cnt  = write_cnt + 1;
      last_widx  = w_index;
      last_wdata = w_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Latency k counts rising edges from the accepting edge (k=1) to the edge
  // after which rsp_valid_o is first seen high.
  task automatic do_req(input logic [W-1:0] key, input logic ins, input int hold,
                        input int exp_lat, input logic exp_hit, input logic exp_ins,
                        input logic [AW-1:0] exp_idx, input int exp_writes);
    int k;
    int w0;
    w0 = write_cnt;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_key    = key;
    req_insert = ins;
    rsp_ready  = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    chk("search_en", s_en, 1);
    chk("search_data", s_data, key);
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (k == 2) chk("search_one_cycle", s_en, 0);
    end
    chk("latency", k, exp_lat);
    chk("rsp_hit", rsp_hit, exp_hit);
    chk("rsp_inserted", rsp_inserted, exp_ins);
    chk("rsp_index", rsp_index, exp_idx);
    chk("req_ready_busy", req_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_hit", rsp_hit, exp_hit);
      chk("bp_inserted", rsp_inserted, exp_ins);
      chk("bp_index", rsp_index, exp_idx);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_consumed", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("write_count", write_cnt - w0, exp_writes);
    if (exp_writes > 0) begin
      chk("write_index", last_widx, exp_idx);
      chk("write_data", last_wdata, key);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_fields"}, {rsp_hit, rsp_inserted, rsp_index}, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_search"}, {s_en, s_data}, 0);
    chk({tag, "_write"}, {w_en, w_index, w_data}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int w_at_rst;
    int k;
    do_reset();

    do_req(32'hDEADBEEF, 1'b1, 0, 4, 1'b0, 1'b1, 5'd0, 1);
    chk("occ_after_insert", occupancy, 1);
    do_req(32'hDEADBEEF, 1'b0, 0, 3, 1'b1, 1'b0, 5'd0, 0);
    do_req(32'h12345678, 1'b0, 0, 3, 1'b0, 1'b0, 5'd0, 0);
    chk("occ_after_miss", occupancy, 1);
    do_req(32'hDEADBEEF, 1'b1, 0, 3, 1'b1, 1'b0, 5'd0, 0);
    chk("occ_after_dup", occupancy, 1);

    do_reset();
    for (int i = 1; i <= 33; i++) begin
      do_req(W'(i), 1'b1, 0, 4, 1'b0, 1'b1, AW'((i - 1) % 32), 1);
      if (i == 31) chk("occ_31", occupancy, 31);
    end
    chk("occ_saturated", occupancy, 32);
    do_req(32'd1, 1'b0, 0, 3, 1'b0, 1'b0, 5'd0, 0);
    do_req(32'd33, 1'b0, 0, 3, 1'b1, 1'b0, 5'd0, 0);
    do_req(32'd2, 1'b0, 0, 3, 1'b1, 1'b0, 5'd1, 0);
    do_req(32'd33, 1'b0, 5, 3, 1'b1, 1'b0, 5'd0, 0);
    do_req(32'd77, 1'b1, 5, 4, 1'b0, 1'b1, 5'd1, 1);
    chk("occ_still_sat", occupancy, 32);

    // Abort an insert in the middle of its WRITE cycle
    @(negedge clk);
    req_valid  = 1'b1;
    req_key    = 32'h0000_0099;
    req_insert = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!w_en && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_write", w_en, 1);
    #1;
    w_at_rst = write_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop");
    repeat (3) @(negedge clk);
    chk("no_write_after_reset", write_cnt - w_at_rst, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_release");
    do_req(32'h0000_0099, 1'b1, 0, 4, 1'b0, 1'b1, 5'd0, 1);
    chk("occ_after_abort", occupancy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_lookup_ctrl.md
# cam_lookup_ctrl

Request sequencer that drives the search and write ports of the team's `cam` block. It accepts lookup-or-insert requests over a valid/ready handshake, issues a CAM search, and on a miss can allocate an entry and write the key. It returns hit/index results on a response handshake. It sits between the client logic and the CAM as the initiator side of the CAM's search/write interface.

## Interface
- `WIDTH`, 32: key width; must match the CAM's `WIDTH`.
- `ADDR_WIDTH`, 5: CAM index width. `DEPTH` = 2**`ADDR_WIDTH` entries.
- `clk_i` in 1: single clock. All logic is rising-edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: controller can accept a request.
- `req_key_i` in `WIDTH`: key to look up.
- `req_insert_i` in 1: on a miss, allocate an entry and write the key.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_hit_o` out 1: key was found.
- `rsp_inserted_o` out 1: key was written this request.
- `rsp_index_o` out `ADDR_WIDTH`: index of the matched entry, or of the written entry.
- `occupancy_o` out `ADDR_WIDTH`+1: number of entries allocated since reset. Saturates at `DEPTH`.
- `cam_search_enable_o` out 1, `cam_search_data_o` out `WIDTH`: search request to the CAM.
- `cam_search_valid_i` in 1, `cam_search_index_i` in `ADDR_WIDTH`: CAM result. Valid in the cycle after `cam_search_enable_o`.
- `cam_write_enable_o` out 1, `cam_write_index_o` out `ADDR_WIDTH`, `cam_write_data_o` out `WIDTH`: CAM write port.

## Operation
- **IDLE**
  - `req_ready_o`=1.
  - When `req_valid_i`=1 at the clock edge: register the key and the insert flag, then go to SEARCH.
- **SEARCH**
  - Assert `cam_search_enable_o` for exactly one cycle, with `cam_search_data_o` = the registered key.
  - Go to CHECK.
- **CHECK**
  - Sample `cam_search_valid_i` / `cam_search_index_i`.
  - Hit: go to RESP with hit=1 and index = the CAM index.
  - Miss with insert=1: go to WRITE.
  - Miss with insert=0: go to RESP with hit=0, inserted=0, index=0.
- **WRITE**
  - Assert `cam_write_enable_o` for one cycle, with index = `alloc_ptr` and data = the key.
  - Increment `alloc_ptr` modulo `DEPTH`. It wraps from `DEPTH`-1 to 0.
  - When full, the wrap overwrites the oldest entry (FIFO replacement).
  - `occupancy_o` increments, saturating at `DEPTH`.
  - Go to RESP with hit=0, inserted=1, index = the pre-increment `alloc_ptr`.
- **RESP**
  - `rsp_valid_o`=1. The `rsp_*` fields are held stable until `rsp_ready_i`=1 at an edge, then go to IDLE.
- Outside IDLE, `req_ready_o`=0, so only one request is in flight.
- `cam_*` outputs are 0 in every state that does not drive them. Data buses are held at 0 when their enable is low.
- Duplicate insert of a key already present reports hit=1 and writes nothing.

## Timing
- **Reset values (asynchronous on `rst_ni`=0):**
  - State = IDLE, so `req_ready_o`=1.
  - `rsp_valid_o`, `rsp_hit_o`, `rsp_inserted_o`, `rsp_index_o` = 0.
  - All `cam_*` outputs = 0.
  - `alloc_ptr`=0, `occupancy_o`=0.
- **Latency**, counting the request accepted at edge N:
  - Search at cycle N+1, CHECK at N+2.
  - `rsp_valid_o` rises after edge N+3 for a hit or a non-insert miss.
  - `rsp_valid_o` rises after edge N+4 for an insert.
- If `rsp_ready_i` is already 1, the response is consumed at its first edge, and `req_ready_o` returns in the following cycle.
- Peak throughput is one request per 4 cycles for lookups and one per 5 for inserts.
- Reset mid-operation aborts the request with no response. No CAM write may be issued from the cycle reset asserts. CAM contents are cleared by the CAM's own reset, not by this block.
- `occupancy_o` changes only on the clock edge that ends WRITE.

## Configuration
- Macro: `CAM_LOOKUP_CTRL_STATS_EN`.
- When defined:
  - Adds outputs `hit_count_o` and `miss_count_o`, 16 bits each, reset to 0.
  - Each is a saturating counter (holds at 16'hFFFF), incremented on the CHECK→next transition according to the hit/miss result.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

## Structure
- Shared package `cam_pkg`:
  - State enum `cam_ctrl_state_e` (IDLE, SEARCH, CHECK, WRITE, RESP).
  - Default `WIDTH`/`ADDR_WIDTH` constants, shared with `cam`.
  - Stats counter width constant (16).
- One natural sub-module: `cam_alloc_ptr`, which holds the wrapping allocation pointer and the saturating occupancy counter.
- The FSM and the response registers stay in `cam_lookup_ctrl`.

## Test plan
- **Reset:** hold `rst_ni`=0 → `req_ready_o`=1, `rsp_valid_o`=0, `occupancy_o`=0, all `cam_*`=0.
- **Insert miss:** insert key 32'hDEADBEEF into an empty CAM → one write at index 0 with data 32'hDEADBEEF; response hit=0, inserted=1, index=0 at accept+4; `occupancy_o`=1.
- **Lookup hit:** look up 32'hDEADBEEF with insert=0 → no write; response hit=1, index=0 at accept+3.
- **Lookup miss, no insert:** look up 32'h12345678 with insert=0 → response hit=0, inserted=0, index=0; no write; occupancy unchanged.
- **Fill and wrap:** insert 33 distinct keys (1..33) → `occupancy_o` saturates at 32; the 33rd write goes to index 0; looking up key 1 then misses and key 33 hits at index 0.
- **Backpressure and reset mid-op:**
  - Hold `rsp_ready_i`=0 for 5 cycles → response fields stay stable and `req_ready_o` stays 0.
  - Assert `rst_ni`=0 during WRITE → no write occurs after the reset assertion, and all outputs take their reset values immediately.
